// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// multi-cycle mul/div occupancy for the IF/ID and ID/EX front end, plus
// saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int unsigned MULDIV_LATENCY = 4,   // stall cycles after a mul/div issues, 1..255
    parameter int unsigned CNT_W          = 16   // performance counter width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_registers_Rs,
    input  logic [4:0]       ID_registers_Rt,
    input  logic             ID_uses_Rt,
    input  logic             ID_branch_taken,
    input  logic             ID_muldiv_start,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_register_Rt,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             muldiv_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {
        RUN,
        MULDIV
    } state_t;

    // cnt holds remaining stall cycles minus one, so the counter reloads with LATENCY-1.
    localparam logic [7:0] CNT_INIT = 8'(MULDIV_LATENCY - 1);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             load_use;

    // A load in EX whose destination feeds the ID instruction; $zero never conflicts.
    assign load_use = EX_MemRead && (EX_register_Rt != 5'd0) &&
                      ((EX_register_Rt == ID_registers_Rs) ||
                       (ID_uses_Rt && (EX_register_Rt == ID_registers_Rt)));

    // Next-state, counter updates and same-cycle control outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_d     = stall_q;
        flush_d     = flush_q;
        PC_write    = 1'b1;
        IF_ID_write = 1'b1;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        muldiv_busy = 1'b0;

        if (!rst_n) begin
            // Freeze the front end and squash both pipeline registers while in reset.
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (load_use) begin
                        // Hold PC and IF/ID; any branch or mul/div in ID is retried next cycle.
                        PC_write    = 1'b0;
                        IF_ID_write = 1'b0;
                        ID_EX_flush = 1'b1;
                    end else if (ID_branch_taken) begin
                        IF_ID_flush = 1'b1;
                        if (flush_q != '1) flush_d = flush_q + 1'b1;
                    end else if (ID_muldiv_start) begin
                        state_d = MULDIV;
                        cnt_d   = CNT_INIT;
                    end
                end
                MULDIV: begin
                    muldiv_busy = 1'b1;
                    PC_write    = 1'b0;
                    IF_ID_write = 1'b0;
                    ID_EX_flush = 1'b1;
                    if (cnt_q == 8'd0) state_d = RUN;
                    else               cnt_d   = cnt_q - 8'd1;
                end
                default: state_d = RUN;
            endcase

            if (!PC_write && (stall_q != '1)) stall_d = stall_q + 1'b1;
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 8'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table of single-cycle vectors from RUN,
// hand-written mul/div and reset sequences, and a narrow-counter saturation run.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       br;
        logic       md;
        logic       memread;
        logic [4:0] ex_rt;
    } in_t;

    // pc_write, if_id_write, if_id_flush, id_ex_flush, muldiv_busy
    typedef struct packed {
        logic pc_w;
        logic ifid_w;
        logic ifid_f;
        logic idex_f;
        logic busy;
    } exp_t;

    typedef struct {
        string name;
        in_t   in;
        exp_t  exp;
    } vec_t;

    localparam exp_t E_RUN   = exp_t'(5'b11000);
    localparam exp_t E_STALL = exp_t'(5'b00010);
    localparam exp_t E_FLUSH = exp_t'(5'b11100);
    localparam exp_t E_BUSY  = exp_t'(5'b00011);
    localparam exp_t E_RST   = exp_t'(5'b00110);

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, id_br, id_md, ex_memread;
    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, busy;
    logic [15:0] stall_cycles, flush_count;

    logic        s_rst_n;
    logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_flush, s_busy;
    logic [3:0]  s_stall, s_flush;

    int n_checks = 0;
    int n_err    = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    exp_t sb_q[$];
    vec_t vecs[10];

    always #5 clk = ~clk;

    hazard_ctrl #(.MULDIV_LATENCY(4), .CNT_W(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ID_registers_Rs (id_rs),
        .ID_registers_Rt (id_rt),
        .ID_uses_Rt      (id_uses_rt),
        .ID_branch_taken (id_br),
        .ID_muldiv_start (id_md),
        .EX_MemRead      (ex_memread),
        .EX_register_Rt  (ex_rt),
        .PC_write        (pc_write),
        .IF_ID_write     (if_id_write),
        .IF_ID_flush     (if_id_flush),
        .ID_EX_flush     (id_ex_flush),
        .muldiv_busy     (busy),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    // Narrow-counter instance held in a permanent load-use stall.
    hazard_ctrl #(.MULDIV_LATENCY(4), .CNT_W(4)) dut_sat (
        .clk             (clk),
        .rst_n           (s_rst_n),
        .ID_registers_Rs (5'd3),
        .ID_registers_Rt (5'd0),
        .ID_uses_Rt      (1'b0),
        .ID_branch_taken (1'b0),
        .ID_muldiv_start (1'b0),
        .EX_MemRead      (1'b1),
        .EX_register_Rt  (5'd3),
        .PC_write        (s_pc_write),
        .IF_ID_write     (s_if_id_write),
        .IF_ID_flush     (s_if_id_flush),
        .ID_EX_flush     (s_id_ex_flush),
        .muldiv_busy     (s_busy),
        .stall_cycles    (s_stall),
        .flush_count     (s_flush)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle after the falling edge, compare the combinational outputs,
    // then compare the counters after the following rising edge.
    task automatic step(input string name, input in_t in, input exp_t e);
        exp_t got_exp;
        @(negedge clk);
        rst_n      = in.rst_n;
        id_rs      = in.rs;
        id_rt      = in.rt;
        id_uses_rt = in.uses_rt;
        id_br      = in.br;
        id_md      = in.md;
        ex_memread = in.memread;
        ex_rt      = in.ex_rt;
        sb_q.push_back(e);
        #2;
        got_exp = sb_q.pop_front();
        check({name, " ctrl"}, {27'd0, pc_write, if_id_write, if_id_flush, id_ex_flush, busy},
              {27'd0, got_exp});
        if (!in.rst_n) begin
            exp_stall = 0;
            exp_flush = 0;
        end else if (!got_exp.pc_w) begin
            if (exp_stall < 65535) exp_stall++;
        end else if (got_exp.ifid_f) begin
            if (exp_flush < 65535) exp_flush++;
        end
        @(posedge clk);
        #1;
        check({name, " stall_cycles"}, {16'd0, stall_cycles}, exp_stall);
        check({name, " flush_count"},  {16'd0, flush_count},  exp_flush);
    endtask

    initial begin
        //                   rst   rs     rt    urt   br    md    mr    ex_rt
        vecs[0] = '{"idle",       in_t'({1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0}), E_RUN};
        vecs[1] = '{"lu_rs",      in_t'({1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5}), E_STALL};
        vecs[2] = '{"lu_zero",    in_t'({1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0}), E_RUN};
        vecs[3] = '{"rt_unused",  in_t'({1'b1, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7}), E_RUN};
        vecs[4] = '{"lu_rt",      in_t'({1'b1, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7}), E_STALL};
        vecs[5] = '{"bubble",     in_t'({1'b1, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9}), E_RUN};
        vecs[6] = '{"branch",     in_t'({1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4}), E_FLUSH};
        vecs[7] = '{"br_lu",      in_t'({1'b1, 5'd6, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6}), E_STALL};
        vecs[8] = '{"br_retry",   in_t'({1'b1, 5'd6, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd6}), E_FLUSH};
        vecs[9] = '{"br_over_md", in_t'({1'b1, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0}), E_FLUSH};

        rst_n = 1'b0; s_rst_n = 1'b0;
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_br = 1'b0; id_md = 1'b0;
        ex_memread = 1'b0; ex_rt = '0;

        // Reset held for three cycles, with hazard-looking inputs that must be ignored.
        for (int i = 0; i < 3; i++)
            step("reset", in_t'({1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5}), E_RST);
        step("post_reset", vecs[0].in, E_RUN);

        // Single-cycle vectors from RUN.
        for (int i = 0; i < 10; i++) step(vecs[i].name, vecs[i].in, vecs[i].exp);
        step("after_br_md", vecs[0].in, E_RUN);

        // Mul/div issue, four busy cycles (branch and load-use ignored), back to RUN.
        step("md_issue", in_t'({1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0}), E_RUN);
        step("md_busy1", vecs[0].in, E_BUSY);
        step("md_busy2", in_t'({1'b1, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0}), E_BUSY);
        step("md_busy3", vecs[1].in, E_BUSY);
        step("md_busy4", in_t'({1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0}), E_BUSY);
        step("md_done",  vecs[0].in, E_RUN);

        // Reset on the second busy cycle aborts the stall and clears the counters.
        step("md2_issue", in_t'({1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0}), E_RUN);
        step("md2_busy1", vecs[0].in, E_BUSY);
        step("md2_reset", in_t'({1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0}), E_RST);
        step("md2_after", vecs[0].in, E_RUN);
        step("md2_after2", vecs[6].in, E_FLUSH);

        // Saturation: release the narrow instance into a continuous stall.
        @(negedge clk);
        s_rst_n = 1'b1;
        for (int i = 0; i < 14; i++) @(posedge clk);
        #1;
        check("sat_stall_14", {28'd0, s_stall}, 32'd14);
        for (int i = 0; i < 6; i++) @(posedge clk);
        #1;
        check("sat_stall_held", {28'd0, s_stall}, 32'd15);
        check("sat_pc_write", {31'd0, s_pc_write}, 32'd0);
        check("sat_flush_count", {28'd0, s_flush}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
